// File: rtl/teclado_pkg.sv
// Shared keypad/display definitions: special key codes, segment patterns and the BCD digit type.
package teclado_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       KEY_CLEAR = 4'hE;
    localparam bcd_t       KEY_BACK  = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/entrada_digitos_display_if.sv
// Key event bundle from the matrix scanner: 4-bit code plus a level-valid held while the key is down.
interface entrada_digitos_display_if;
    import teclado_pkg::*;

    bcd_t key_code_pi;
    logic key_valid_pi;

    modport master (output key_code_pi, output key_valid_pi);
    modport slave  (input  key_code_pi, input  key_valid_pi);
endinterface

// File: rtl/decodificador_7seg.sv
// BCD to active-low 7-segment decoder, segments ordered {g,f,e,d,c,b,a}; non-decimal nibbles blank.
module decodificador_7seg
    import teclado_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_ZERO;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/entrada_digitos_display.sv
// Keypad-driven 4-digit decimal entry buffer (backspace/clear) with a multiplexed
// common-anode 7-segment display scan.
module entrada_digitos_display
    import teclado_pkg::*;
#(
    parameter int REFRESH_CNT = 27000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    entrada_digitos_display_if.slave        key_if,
    output logic [15:0]                     digits_po,
    output logic [2:0]                      count_po,
    output logic                            full_po,
    output logic [3:0]                      anodo_po,
    output logic [6:0]                      catodo_po
);

    localparam int         CNT_W      = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [2:0] FULL_COUNT = 3'(NUM_DIGITS);

    bcd_t [3:0]       digits_q, digits_d;
    logic [2:0]       count_q, count_d;
    logic             key_valid_q;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       anodo_q, anodo_d;
    logic [6:0]       catodo_q, catodo_d;
    logic [6:0]       seg_sel;
    logic             press;

    assign press = key_if.key_valid_pi & ~key_valid_q;

    // NOTE: always_comb uses blocking '=' with a default first so no path leaves a latch.
    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        if (press) begin
            if (key_if.key_code_pi <= 4'd9) begin
                if (count_q < FULL_COUNT) begin
                    digits_d = {digits_q[2:0], key_if.key_code_pi};
                    count_d  = count_q + 3'd1;
                end
            end else if (key_if.key_code_pi == KEY_BACK) begin
                if (count_q != 3'd0) begin
                    digits_d = {bcd_t'(4'h0), digits_q[3:1]};
                    count_d  = count_q - 3'd1;
                end
            end else if (key_if.key_code_pi == KEY_CLEAR) begin
                digits_d = '0;
                count_d  = 3'd0;
            end
        end
    end

    always_comb begin
        refresh_d = refresh_q + CNT_W'(1);
        sel_d     = sel_q;
        if (refresh_q == CNT_LAST) begin
            refresh_d = '0;
            sel_d     = sel_q + 2'd1;
        end
    end

    decodificador_7seg u_dec (
        .bcd_i (digits_q[sel_q]),
        .seg_o (seg_sel)
    );

    // An empty buffer still shows a single '0' on the rightmost digit.
    always_comb begin
        anodo_d = ~(4'b0001 << sel_q);
        if ({1'b0, sel_q} < count_q)
            catodo_d = seg_sel;
        else if (count_q == 3'd0 && sel_q == 2'd0)
            catodo_d = SEG_ZERO;
        else
            catodo_d = SEG_BLANK;
    end

    // NOTE: sequential state uses non-blocking '<='; key_valid_q resets high so a key
    // held across reset release must be released before it can register a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits_q    <= '0;
            count_q     <= 3'd0;
            key_valid_q <= 1'b1;
            refresh_q   <= '0;
            sel_q       <= 2'd0;
            anodo_q     <= 4'b1111;
            catodo_q    <= SEG_BLANK;
        end else begin
            digits_q    <= digits_d;
            count_q     <= count_d;
            key_valid_q <= key_if.key_valid_pi;
            refresh_q   <= refresh_d;
            sel_q       <= sel_d;
            anodo_q     <= anodo_d;
            catodo_q    <= catodo_d;
        end
    end

    assign digits_po = digits_q;
    assign count_po  = count_q;
    assign full_po   = (count_q == FULL_COUNT);
    assign anodo_po  = anodo_q;
    assign catodo_po = catodo_q;

endmodule
